// File: rtl/riscv_decode_buffer.sv
// riscv_decode_buffer: RV32I field split, format classification, immediate
// rebuild and illegal-encoding detection, followed by a 2-entry skid buffer.
// Outputs always come from the head register; in_ready depends only on the
// registered occupancy, so there is no combinational path from out_ready.
module riscv_decode_buffer #(
  parameter int XLEN          = 32,
  parameter bit ENABLE_FENCE  = 1'b1,
  parameter bit ENABLE_SYSTEM = 1'b1,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [6:0]           out_opcode,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  // opcode encodings (opcodeType_e)
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BRCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_ECBK  = 7'b1110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_BAD = 3'd7;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [2:0]        w_fmt_raw;
  logic              w_bad;
  logic [2:0]        w_fmt;
  logic signed [31:0] w_imm32;
  entry_t            w_dec;
  logic              w_push;
  logic              w_pop;

  entry_t                r_ent0;
  entry_t                r_ent1;
  logic [1:0]            r_count;
  logic [ERR_CNT_W-1:0]  r_err;

  assign w_op = in_inst[6:0];
  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];

  // classify format by opcode and flag reserved/unsupported encodings
  always_comb begin
    w_fmt_raw = FMT_BAD;
    w_bad     = 1'b0;
    case (w_op)
      OP_ALU: begin
        w_fmt_raw = FMT_R;
        if (w_f7 != F7_ZERO && w_f7 != F7_ALT) w_bad = 1'b1;
        else if (w_f7 == F7_ALT && w_f3 != 3'b000 && w_f3 != 3'b101) w_bad = 1'b1;
      end
      OP_JALR: begin
        w_fmt_raw = FMT_I;
        if (w_f3 != 3'b000) w_bad = 1'b1;
      end
      OP_LOAD: begin
        w_fmt_raw = FMT_I;
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_bad = 1'b1;
      end
      OP_ALUI: begin
        w_fmt_raw = FMT_I;
        if (w_f3 == 3'b001 && w_f7 != F7_ZERO) w_bad = 1'b1;
        if (w_f3 == 3'b101 && w_f7 != F7_ZERO && w_f7 != F7_ALT) w_bad = 1'b1;
      end
      OP_FENCE: begin
        w_fmt_raw = FMT_I;
        if (!ENABLE_FENCE) w_bad = 1'b1;
      end
      OP_ECBK: begin
        w_fmt_raw = FMT_I;
        // only ECALL (imm 0) and EBREAK (imm 1) with zero rd/rs1/funct3
        if (!ENABLE_SYSTEM || w_f3 != 3'b000 || in_inst[11:7] != 5'd0 ||
            in_inst[19:15] != 5'd0 || in_inst[31:21] != 11'd0) w_bad = 1'b1;
      end
      OP_STORE: begin
        w_fmt_raw = FMT_S;
        if (w_f3 > 3'b010) w_bad = 1'b1;
      end
      OP_BRCH: begin
        w_fmt_raw = FMT_B;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_bad = 1'b1;
      end
      OP_LUI, OP_AUIPC: w_fmt_raw = FMT_U;
      OP_JAL:           w_fmt_raw = FMT_J;
      default:          w_bad = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) w_bad = 1'b1;
  end

  assign w_fmt = w_bad ? FMT_BAD : w_fmt_raw;

  // rebuild the 32-bit immediate for the final format; R and BAD carry zero
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U: w_imm32 = {in_inst[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                        in_inst[20], in_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // assemble the decoded record that is written on an input handshake
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.opcode  = w_op;
    w_dec.rd      = in_inst[11:7];
    w_dec.rs1     = in_inst[19:15];
    w_dec.rs2     = in_inst[24:20];
    w_dec.funct3  = w_f3;
    w_dec.funct7  = w_f7;
    w_dec.imm     = XLEN'(w_imm32);
    w_dec.fmt     = w_fmt;
    w_dec.illegal = w_bad;
  end

  assign in_ready  = ~r_count[1];
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // two-entry buffer: head in r_ent0, second entry in r_ent1; flush wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= w_dec;
          else                 r_ent1 <= w_dec;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        // push and pop together only happens with one entry: replace the head
        2'b11: r_ent0 <= w_dec;
        default: ;
      endcase
    end
  end

  // saturating count of illegal entries delivered downstream (flush included)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_pop && r_ent0.illegal && r_err != {ERR_CNT_W{1'b1}}) begin
      r_err <= r_err + ERR_CNT_W'(1);
    end
  end

  assign out_pc      = r_ent0.pc;
  assign out_opcode  = r_ent0.opcode;
  assign out_rd      = r_ent0.rd;
  assign out_rs1     = r_ent0.rs1;
  assign out_rs2     = r_ent0.rs2;
  assign out_funct3  = r_ent0.funct3;
  assign out_funct7  = r_ent0.funct7;
  assign out_imm     = r_ent0.imm;
  assign out_fmt     = r_ent0.fmt;
  assign out_illegal = r_ent0.illegal;
  assign err_count   = r_err;

endmodule

// File: doc/riscv_decode_buffer.md
# riscv_decode_buffer

Parametrised RV32I decode stage with a 2-entry skid buffer. It sits between instruction fetch and the register-read/execute stage. Each accepted instruction word is split into opcode, register and funct fields, its format is classified, the immediate is rebuilt and sign-extended to XLEN, and illegal encodings are flagged. Input and output use valid/ready handshakes; a synchronous flush discards everything in flight.

## Interface
Parameters:
- XLEN, 32, width of pc and imm; must be ≥32; immediates sign-extended to XLEN
- ENABLE_FENCE, 1, 0 makes opcode FENCE (7'b0001111) illegal
- ENABLE_SYSTEM, 1, 0 makes opcode ECBK_C (7'b1110011) illegal
- ERR_CNT_W, 16, width of saturating illegal-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  buffer can accept (entries < 2)
- in_inst  in  32  instruction word, instruction_u layout
- in_pc  in  XLEN  pc of in_inst
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_pc  out  XLEN
- out_opcode  out  7  opcodeType_e
- out_rd, out_rs1, out_rs2  out  5 each  raw fields inst[11:7], [19:15], [24:20]
- out_funct3  out  3
- out_funct7  out  7
- out_imm  out  XLEN  reconstructed immediate
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, BAD=7
- out_illegal  out  1  head entry is an illegal encoding
- err_count  out  ERR_CNT_W  illegal instructions delivered, saturating

## Operation
- Decode is combinational on in_inst. The decoded record is written into the buffer on the input handshake (in_valid & in_ready). Outputs come from the head entry register.
- Format by opcode:
  - R: ALU_C
  - I: JALR, LOAD_C, ALUI_C, FENCE, ECBK_C
  - S: STORE_C
  - B: BRCH_C
  - U: LUI, AUIPC
  - J: JAL
  - anything else: BAD
- Immediates, all sign-extended from inst[31]:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R and BAD: 0
- out_illegal is set (and out_fmt = BAD) when any of these holds:
  - inst[1:0] ≠ 2'b11, or unknown opcode
  - JALR with funct3 ≠ 0
  - LOAD_C with funct3 ∈ {011, 110, 111}
  - STORE_C with funct3 > 010
  - BRCH_C with funct3 ∈ {010, 011}
  - ALU_C with funct7 ∉ {0000000, 0100000}, or funct7 = 0100000 with funct3 ∉ {000, 101}
  - ALUI_C SLLI with funct7 ≠ 0
  - ALUI_C SRLI_SRAI with funct7 ∉ {0000000, 0100000}
  - ECBK_C unless funct3 = 0, rd = 0, rs1 = 0 and imm ∈ {0, 1}
  - FENCE or ECBK_C while the corresponding ENABLE_* is 0
- Illegal entries still flow through the buffer; they are never dropped.
- err_count increments on each output handshake whose entry is illegal. It saturates at all-ones.

## Timing
- Reset values: buffer empty, out_valid = 0, in_ready = 1, all out_* data = 0, err_count = 0.
- Latency is 1 cycle: an entry accepted at edge N gives out_valid = 1 after edge N.
- Throughput is 1 per cycle when out_ready is held high.
- in_ready = (count < 2). It is driven from registers only, with no combinational path from out_ready.
- Simultaneous push and pop with count = 2 is impossible (in_ready = 0). With count = 1, count stays 1 and the order is preserved.
- When count = 2 and the head pops, in_ready rises the following cycle.
- Output data must remain stable while out_valid & !out_ready.
- flush has priority over push and pop in the same cycle:
  - count → 0; out_valid = 0 next cycle.
  - A concurrent input handshake is discarded.
  - An output handshake in the flush cycle still counts toward err_count if that entry is illegal.
- Asserting rst_n low mid-stream empties the buffer and clears err_count immediately (asynchronously).

## Test plan
- Single ALUI: push 0xFFF00093 (addi x1,x0,-1), pc = 0x100 → next cycle out_valid = 1, fmt I, rd = 1, rs1 = 0, imm = 0xFFFFFFFF, out_illegal = 0, out_pc = 0x100.
- Formats back-to-back with out_ready = 1:
  - 0x123452B7 → U, rd = 5, imm = 0x12345000
  - 0xFE000EE3 → B, imm = 0xFFFFFFFC
  - 0x0000006F → J, imm = 0
  - 0x00A12023 → S, rs2 = 10, rs1 = 2, imm = 0
  - all one per cycle, in order
- Backpressure: out_ready = 0, push 3 words → in_ready drops after 2 accepted and the third is held by fetch; then release out_ready → all 3 delivered in order with no duplicates.
- Illegal detection: push 0x00000000, 0x40001033 (funct7 0100000 on SLL) and 0x0000300F with ENABLE_FENCE = 0 → each out_illegal = 1, fmt = 7, err_count = 3. Force err_count to all-ones and push another illegal word → it stays saturated.
- Flush: 2 entries buffered, assert flush together with in_valid → next cycle out_valid = 0, in_ready = 1, and the flushed-cycle input never appears.
- Reset: assert rst_n low while 2 entries are buffered → out_valid = 0, err_count = 0 immediately, without waiting for a clock edge.
